// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues one imem request at a time from the current pc,
// registers the returned word and hands it to decode under valid/ready.
module ifetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        pc_advance,
  output logic        misaligned_fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  state_t       state, state_nxt;
  fetch_entry_t entry_q;
  logic [31:0]  pc_q;
  logic         aligned;
  logic         latch_pc, load_mem, load_nop, clr_vld;

  assign aligned          = (pc[1:0] == 2'b00);
  assign imem_addr        = pc;
  assign instr            = entry_q.instr;
  assign instr_pc         = entry_q.pc;
  assign misaligned_fault = entry_q.fault;

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    latch_pc   = 1'b0;
    load_mem   = 1'b0;
    load_nop   = 1'b0;
    clr_vld    = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (aligned) begin
          // redirect without gnt needs no action: imem_addr already follows the new pc
          imem_req = 1'b1;
          if (imem_gnt) begin
            if (redirect) state_nxt = DROP;
            else begin
              state_nxt = WAIT;
              latch_pc  = 1'b1;
            end
          end
        end else if (!redirect) begin
          load_nop  = 1'b1;
          state_nxt = HOLD;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect) state_nxt = REQ;
          else begin
            load_mem  = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: if (imem_rvalid) state_nxt = REQ;
      HOLD: begin
        if (redirect) begin
          clr_vld   = 1'b1;
          state_nxt = REQ;
        end else if (instr_ready) begin
          pc_advance = 1'b1;
          clr_vld    = 1'b1;
          state_nxt  = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_valid <= 1'b0;
      entry_q     <= '0;
      pc_q        <= '0;
    end else begin
      state <= state_nxt;
      if (latch_pc) pc_q <= pc;
      if (load_mem) begin
        entry_q     <= '{instr: imem_rdata, pc: pc_q, fault: 1'b0};
        instr_valid <= 1'b1;
      end
      if (load_nop) begin
        entry_q     <= '{instr: NOP_INSTR, pc: pc, fault: 1'b1};
        instr_valid <= 1'b1;
      end
      if (clr_vld) instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table, a hand-written reset-in-WAIT
// sequence, then random traffic against a memory model and pc-register model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst, redirect, imem_gnt, imem_rvalid, instr_ready;
  logic [31:0] pc, imem_rdata;
  logic        imem_req, instr_valid, pc_advance, misaligned_fault;
  logic [31:0] imem_addr, instr, instr_pc;

  ifetch_unit dut (
    .clk(clk), .rst(rst), .pc(pc), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .pc_advance(pc_advance),
    .misaligned_fault(misaligned_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] pc;
    bit          redir, gnt, rvalid;
    logic [31:0] rdata;
    bit          rdy, chk, e_req;
    logic [31:0] e_addr;
    bit          e_adv, e_vld;
    logic [31:0] e_instr, e_ipc;
    bit          e_flt;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(bit r, logic [31:0] p, bit rd, bit g, bit rv, logic [31:0] dat, bit rdy,
                              bit c, bit eq, logic [31:0] ea, bit eadv, bit ev,
                              logic [31:0] ei, logic [31:0] eip, bit ef);
    vec_t v;
    v.rst = r; v.pc = p; v.redir = rd; v.gnt = g; v.rvalid = rv; v.rdata = dat; v.rdy = rdy;
    v.chk = c; v.e_req = eq; v.e_addr = ea; v.e_adv = eadv; v.e_vld = ev;
    v.e_instr = ei; v.e_ipc = eip; v.e_flt = ef;
    return v;
  endfunction

  function automatic logic [31:0] memfn(logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    rst = v.rst; pc = v.pc; redirect = v.redir; imem_gnt = v.gnt;
    imem_rvalid = v.rvalid; imem_rdata = v.rdata; instr_ready = v.rdy;
    #1;
    if (v.chk) begin
      chk({nm, ".req"}, 32'(imem_req), 32'(v.e_req));
      if (v.e_req) chk({nm, ".addr"}, imem_addr, v.e_addr);
      chk({nm, ".adv"},   32'(pc_advance), 32'(v.e_adv));
      chk({nm, ".vld"},   32'(instr_valid), 32'(v.e_vld));
      chk({nm, ".instr"}, instr, v.e_instr);
      chk({nm, ".ipc"},   instr_pc, v.e_ipc);
      chk({nm, ".flt"},   32'(misaligned_fault), 32'(v.e_flt));
    end
  endtask

  initial begin
    logic [31:0] pcr, pdata;
    bit          pend, acc, req_s, adv_s;
    int          dly, delivered;

    rst = 1'b1; pc = '0; redirect = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

    // basic fetch, back-pressure, redirects in WAIT, misaligned pc
    tbl.push_back(mk(1, 0, 0,0,0,0,0, 0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0, 0, 0,0,0,0,0, 1, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0, 0, 0,1,0,0,0, 1, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0, 0, 0,0,1,32'h00500093,0, 1, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0, 0, 0,0,0,0,1, 1, 0,0,1,1,32'h00500093,0,0));
    tbl.push_back(mk(0, 4, 0,1,0,0,0, 1, 1,4,0,0,32'h00500093,0,0));
    tbl.push_back(mk(0, 4, 0,0,1,32'h00108113,0, 1, 0,0,0,0,32'h00500093,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4, 0,0,0,0,0, 1, 0,0,0,1,32'h00108113,4,0));
    tbl.push_back(mk(0, 4, 0,0,0,0,1, 1, 0,0,1,1,32'h00108113,4,0));
    tbl.push_back(mk(0, 8, 0,1,0,0,0, 1, 1,8,0,0,32'h00108113,4,0));
    tbl.push_back(mk(0, 32'h40, 1,0,0,0,0, 1, 0,0,0,0,32'h00108113,4,0));
    tbl.push_back(mk(0, 32'h40, 0,0,1,32'hDEADBEEF,0, 1, 0,0,0,0,32'h00108113,4,0));
    tbl.push_back(mk(0, 32'h40, 0,1,0,0,0, 1, 1,32'h40,0,0,32'h00108113,4,0));
    tbl.push_back(mk(0, 32'h80, 1,0,1,32'h11111111,0, 1, 0,0,0,0,32'h00108113,4,0));
    tbl.push_back(mk(0, 32'h80, 0,1,0,0,0, 1, 1,32'h80,0,0,32'h00108113,4,0));
    tbl.push_back(mk(0, 32'h80, 0,0,1,32'h22222293,0, 1, 0,0,0,0,32'h00108113,4,0));
    tbl.push_back(mk(0, 32'h80, 0,0,0,0,1, 1, 0,0,1,1,32'h22222293,32'h80,0));
    tbl.push_back(mk(0, 32'h102, 0,0,0,0,0, 1, 0,0,0,0,32'h22222293,32'h80,0));
    tbl.push_back(mk(0, 32'h102, 0,0,0,0,0, 1, 0,0,0,1,32'h13,32'h102,1));
    tbl.push_back(mk(0, 32'h102, 0,0,0,0,1, 1, 0,0,1,1,32'h13,32'h102,1));
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // gnt stall with pc moving, then reset during WAIT
    apply(mk(0, 32'h300, 1,0,0,0,0, 1, 1,32'h300,0,0,32'h13,32'h102,1), "stall0");
    apply(mk(0, 32'h300, 0,0,0,0,0, 1, 1,32'h300,0,0,32'h13,32'h102,1), "stall1");
    apply(mk(0, 32'h310, 1,0,0,0,0, 1, 1,32'h310,0,0,32'h13,32'h102,1), "stall2");
    apply(mk(0, 32'h310, 0,0,0,0,0, 1, 1,32'h310,0,0,32'h13,32'h102,1), "stall3");
    apply(mk(0, 32'h310, 0,1,0,0,0, 1, 1,32'h310,0,0,32'h13,32'h102,1), "grant");
    apply(mk(0, 32'h310, 0,0,0,0,0, 1, 0,0,0,0,32'h13,32'h102,1), "wait");
    apply(mk(1, 32'h310, 0,0,0,0,0, 1, 0,0,0,0,32'h13,32'h102,1), "rstwait");
    apply(mk(0, 32'h310, 0,0,0,0,0, 1, 0,0,0,0,0,0,0), "postrst");
    apply(mk(0, 32'h310, 0,1,0,0,0, 1, 1,32'h310,0,0,0,0,0), "freshreq");
    apply(mk(0, 32'h310, 0,0,1,32'h33333313,0, 1, 0,0,0,0,0,0,0), "freshdata");
    apply(mk(0, 32'h310, 0,0,0,0,1, 1, 0,0,1,1,32'h33333313,32'h310,0), "freshacc");

    // random traffic: the accepted instruction must always belong to the pc the PC register holds
    apply(mk(1, 0, 0,0,0,0,0, 0, 0,0,0,0,0,0,0), "rndrst");
    pcr = '0; pend = 1'b0; dly = 0; pdata = '0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      redirect = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        redirect = 1'b1;
        pcr = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 9) == 0) pcr = pcr | 32'd2;
      end
      pc = pcr;
      instr_ready = ($urandom_range(0, 2) != 0);
      imem_rvalid = pend && (dly == 0);
      imem_rdata  = imem_rvalid ? pdata : $urandom;
      imem_gnt    = 1'b0;
      #1;
      req_s = imem_req;
      adv_s = pc_advance;
      if (req_s) begin
        chk("rnd.addr", imem_addr, pcr);
        chk("rnd.one_outstanding", 32'(pend), 32'd0);
        imem_gnt = ($urandom_range(0, 2) != 0);
      end
      if (pcr[1:0] != 2'b00) chk("rnd.misaligned_noreq", 32'(req_s), 32'd0);
      acc = instr_valid && instr_ready && !redirect;
      chk("rnd.pc_advance", 32'(adv_s), 32'(acc));
      if (acc) begin
        delivered++;
        chk("rnd.instr_pc", instr_pc, pcr);
        if (pcr[1:0] != 2'b00) begin
          chk("rnd.instr_nop", instr, 32'h00000013);
          chk("rnd.fault", 32'(misaligned_fault), 32'd1);
        end else begin
          chk("rnd.instr", instr, memfn(pcr));
          chk("rnd.fault", 32'(misaligned_fault), 32'd0);
        end
      end
      @(posedge clk);
      if (imem_rvalid) pend = 1'b0;
      else if (pend) dly--;
      if (req_s && imem_gnt) begin
        pend  = 1'b1;
        dly   = $urandom_range(0, 3);
        pdata = memfn(pcr);
      end
      if (adv_s) pcr = pcr + 32'd4;
    end
    chk("rnd.delivered_some", 32'(delivered > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of the PC register. It takes the current PC and issues one request at a time to instruction memory over a req/gnt + rvalid handshake. It registers the returned word together with its PC and presents it to decode under a valid/ready handshake. It pulses pc_advance to let the PC register step, and discards stale fetches when a redirect (branch, jal or jalr taken) arrives.

Parameters:
NOP_INSTR, 32'h00000013, word presented on instr when a misaligned fault is reported (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on posedge clk.
rst  in  1  synchronous, active-high reset.
pc  in  32  current PC from the PC register; sampled in REQ state.
redirect  in  1  PC was overwritten by a control transfer; kill in-flight or held fetch.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; equals pc while imem_req=1.
imem_gnt  in  1  memory accepted request this cycle (valid only when imem_req=1).
imem_rvalid  in  1  read data valid; at most one per granted request, earliest 1 cycle after gnt.
imem_rdata  in  32  instruction word.
instr_valid  out  1  instr/instr_pc/misaligned_fault are valid for decode.
instr  out  32  fetched instruction.
instr_pc  out  32  PC of instr.
instr_ready  in  1  decode accepts the instruction this cycle.
pc_advance  out  1  one-cycle pulse; PC register steps on this edge.
misaligned_fault  out  1  instr_valid entry came from a PC with pc[1:0]!=0.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; instr_valid=0, instr=0, instr_pc=0, misaligned_fault=0. Combinational outputs imem_req=0 and pc_advance=0 while in IDLE.
- States: IDLE, REQ, WAIT, DROP, HOLD.
- IDLE: unconditionally go to REQ next cycle.
- REQ, pc[1:0]==0: imem_req=1, imem_addr=pc (combinational follow).
  - gnt=1 and redirect=0 -> WAIT, latch pc into pc_q.
  - gnt=1 and redirect=1 -> DROP.
  - gnt=0 -> stay in REQ. redirect is ignored here because the new pc is already on imem_addr.
- REQ, pc[1:0]!=0: imem_req=0. Load instr=NOP_INSTR, instr_pc=pc, misaligned_fault=1, instr_valid=1 -> HOLD. With redirect=1 this cycle, stay in REQ instead.
- WAIT:
  - rvalid=1 and redirect=0: instr<=imem_rdata, instr_pc<=pc_q, misaligned_fault<=0, instr_valid<=1 -> HOLD.
  - rvalid=1 and redirect=1: discard the data -> REQ.
  - rvalid=0 and redirect=1 -> DROP.
  - Otherwise stay in WAIT.
- DROP: wait for the outstanding rvalid, discard its data -> REQ. Further redirects in DROP have no extra effect.
- HOLD: instr_valid=1 and the output registers are stable.
  - instr_ready=1 and redirect=0: pc_advance=1 (combinational, same cycle), instr_valid<=0 -> REQ. The next REQ cycle sees the stepped pc.
  - redirect=1: instr_valid<=0, pc_advance=0 -> REQ, regardless of instr_ready.
- pc_advance is asserted only in HOLD with the handshake completed, so it occurs at most once per delivered instruction and never in any other state.
- Only one outstanding memory request at a time. imem_req=0 in WAIT, DROP, HOLD and IDLE.
- Reset mid-operation: go straight to IDLE and drop any pending rvalid. The memory must also be reset by the same rst.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD) with gnt=1 immediately, rvalid the next cycle and instr_ready=1.

Test Plan:
1. Reset, then pc=0x0, gnt=1 immediately, rvalid with 0x00500093 one cycle later, instr_ready=1 -> imem_addr=0x0, then instr=0x00500093, instr_pc=0x0, pc_advance pulses once; the next request has addr=0x4.
2. Back-pressure: instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc are held and stable, pc_advance=0, no imem_req. Then ready=1 -> a single pc_advance pulse.
3. Redirect in WAIT with pc changing to 0x40 -> rvalid data 0xDEADBEEF is discarded (instr_valid stays 0). The next imem_addr=0x40 with no pc_advance.
4. Redirect coincident with rvalid in WAIT -> data dropped, state returns to REQ, the following fetch uses the new pc.
5. pc=0x00000102 -> no imem_req, instr_valid=1, instr=0x00000013, instr_pc=0x102, misaligned_fault=1.
6. gnt held low for 4 cycles, then rst=1 for one cycle during a later WAIT -> imem_addr tracks pc throughout the gnt stall. After reset, all outputs are 0 and a fresh request is issued from REQ two cycles later.
